// File: rtl/pri_encoder_scan.sv
// Sequential priority encoder: accepts a request word, then emits one beat per set bit, lowest index first.
// Optional popcount output out_cnt is built only when ENC_COUNT_EN is defined.
module pri_encoder_scan #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_none
`ifdef ENC_COUNT_EN
    ,
    output logic [W:0]   out_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_pend;
    logic           r_zero;
    logic [W-1:0]   w_low;
    logic           w_one;
    logic           w_accept;
    logic           w_fire;
    logic           w_last;

    // Lowest set bit of the pending word; 0 when nothing is pending.
    always_comb begin
        w_low = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (r_pend[i-1]) begin
                w_low = W'(i - 1);
            end
        end
    end

    assign w_one    = (r_pend != '0) && ((r_pend & (r_pend - N'(1))) == '0);
    assign w_last   = r_zero || w_one;
    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_fire   = (r_state == SCAN) && out_ready;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = SCAN;
            SCAN: if (w_fire && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == SCAN);
        out_idx   = (r_state == SCAN && !r_zero) ? w_low : '0;
        out_last  = (r_state == SCAN) && w_last;
        out_none  = (r_state == SCAN) && r_zero;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_pend <= '0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_pend <= in_req;
            r_zero <= (in_req == '0);
        end else if (w_fire) begin
            r_pend[w_low] <= 1'b0;
            if (w_last) begin
                r_zero <= 1'b0;
            end
        end
    end

`ifdef ENC_COUNT_EN
    logic [W:0] r_cnt;
    logic [W:0] w_pop;

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_pop = w_pop + (W+1)'(in_req[i]);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_pop;
        end else if (w_fire && w_last) begin
            r_cnt <= '0;
        end
    end

    assign out_cnt = r_cnt;
`endif

endmodule
